// File: rtl/inst_loader.sv
// Instruction RAM loader: assembles a big-endian byte stream (word count, then
// words) into the instruction RAM, then releases the core and serves its fetches.
module inst_loader #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [WIDTH-1:0]  program_counter,
  output logic [WIDTH-1:0]  inst,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              load_err,
  output logic [ADDR_W:0]   loaded_words
);
  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [32:0] DEPTH_CMP = 33'(DEPTH);

  typedef enum logic [1:0] {HDR, DATA, RUN, ERR} state_t;

  state_t            state;
  logic [1:0]        bc;
  logic [23:0]       sh;
  logic [ADDR_W:0]   n_words;
  logic [WIDTH-1:0]  mem [0:DEPTH-1];

  logic [31:0]       word;
  logic              accept;
  logic              word_done;
  logic [ADDR_W:0]   next_count;

  // Bytes only matter while loading; RUN and ERR freeze the assembler.
  assign accept     = rx_valid && (state == HDR || state == DATA);
  assign word_done  = accept && (bc == 2'd3);
  assign word       = {sh, rx_data};
  assign next_count = loaded_words + (ADDR_W+1)'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= HDR;
      bc           <= '0;
      sh           <= '0;
      loaded_words <= '0;
      load_err     <= 1'b0;
      n_words      <= '0;
    end else if (accept) begin
      if (bc != 2'd3) begin
        sh <= {sh[15:0], rx_data};
        bc <= bc + 2'd1;
      end else begin
        bc <= '0;
        if (state == HDR) begin
          if (word == 32'd0) begin
            state <= RUN;
          end else if ({1'b0, word} > DEPTH_CMP) begin
            state    <= ERR;
            load_err <= 1'b1;
          end else begin
            n_words      <= word[ADDR_W:0];
            loaded_words <= '0;
            state        <= DATA;
          end
        end else begin
          loaded_words <= next_count;
          if (next_count == n_words) state <= RUN;
        end
      end
    end
  end

  // RAM is never cleared; only a completed DATA word writes it.
  always_ff @(posedge clk) begin
    if (rstn && word_done && state == DATA)
      mem[loaded_words[ADDR_W-1:0]] <= WIDTH'(word);
  end

  assign cpu_rstn = (state == RUN);
  assign busy     = (state == HDR || state == DATA);

  // Zero-latency fetch; byte offset bits are don't-care.
  logic [ADDR_W-1:0] widx;
  logic              unused_pc;
  assign widx      = program_counter[ADDR_W+1:2];
  assign unused_pc = ^program_counter[1:0];
  assign inst      = (|program_counter[WIDTH-1:ADDR_W+2]) ? '0 : mem[widx];
endmodule
